controlador_double_dabble: RTL and testbench

//  Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm.
//  - One corretor4x4BCD instance per BCD digit; the FSM alternates correct/shift phases, one bit per pass.
//  - Sits between the binary datapath and the 7-segment display drivers.
//  - Single start/busy/done handshake; result held stable until the next conversion completes.

---
 rtl/controlador_double_dabble.sv | 153 +++++++++++++++
 tb/tb_controlador_double_dabble.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/controlador_double_dabble.sv
`default_nettype none
// ============================================================================
//  Module   : controlador_double_dabble
//  Purpose  : Sequential binary-to-BCD converter (shift-and-add-3). One
//             corretor4x4BCD per BCD digit; start/busy/done handshake.
//  Option   : CICLO_UNICO_EN - merge correction and shift into one cycle
//             per input bit (latency N_BITS+1 edges instead of 2*N_BITS+1).
//  Revision : 1.0 - initial release
// ============================================================================

// Single-digit corrector: add 3 when the digit is 5 or more, so the next
// left shift carries correctly into the following decade.
module corretor4x4BCD (
    input  logic [3:0] i_digito,
    output logic [3:0] o_digito
);
    // Carry-out is never needed: a valid digit (<=9) plus 3 still fits 4 bits
    assign o_digito = (i_digito >= 4'd5) ? (i_digito + 4'd3) : i_digito;
endmodule

module controlador_double_dabble #(
    parameter int N_BITS    = 8,
    parameter int N_DIGITOS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [N_BITS-1:0]      bin_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*N_DIGITOS-1:0] bcd_out
);

    localparam int c_BCD_W = 4 * N_DIGITOS;
    localparam int c_SR_W  = c_BCD_W + N_BITS;
    localparam int c_CNT_W = $clog2(N_BITS + 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
`ifndef CICLO_UNICO_EN
    localparam logic [1:0] c_CORRIGE = 2'd1;
`endif
    localparam logic [1:0] c_DESLOCA = 2'd2;
    localparam logic [1:0] c_FIM     = 2'd3;

    logic [1:0]         r_estado;
    logic [1:0]         w_prox;
    logic [c_SR_W-1:0]  r_sr;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_BCD_W-1:0] r_bcd;
    logic [c_BCD_W-1:0] w_corr;
    logic               r_done;

    // One corrector per digit field of the shift register
    generate
        for (genvar g = 0; g < N_DIGITOS; g++) begin : g_corretor
            corretor4x4BCD u_corretor (
                .i_digito (r_sr[N_BITS + 4*g +: 4]),
                .o_digito (w_corr[4*g +: 4])
            );
        end
    endgenerate

    // State register; reset abandons any conversion in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= c_IDLE;
        end else begin
            r_estado <= w_prox;
        end
    end

    // Next-state logic: one correct/shift pass per input bit
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            c_IDLE: begin
                if (start) begin
`ifdef CICLO_UNICO_EN
                    w_prox = c_DESLOCA;
`else
                    w_prox = c_CORRIGE;
`endif
                end
            end
`ifndef CICLO_UNICO_EN
            c_CORRIGE: w_prox = c_DESLOCA;
`endif
            c_DESLOCA: begin
                if (r_cnt == c_CNT_W'(1)) begin
                    w_prox = c_FIM;
                end else begin
`ifdef CICLO_UNICO_EN
                    w_prox = c_DESLOCA;
`else
                    w_prox = c_CORRIGE;
`endif
                end
            end
            c_FIM:   w_prox = c_IDLE;
            default: w_prox = c_IDLE;
        endcase
    end

    // Outputs: busy covers every non-idle state, so it drops at the FIM edge
    always_comb begin
        busy    = (r_estado != c_IDLE);
        done    = r_done;
        bcd_out = r_bcd;
    end

    // Datapath: operand capture, digit correction, shift, result latch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_bcd  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_estado)
                c_IDLE: begin
                    if (start) begin
                        r_sr  <= {{c_BCD_W{1'b0}}, bin_in};
                        r_cnt <= c_CNT_W'(N_BITS);
                    end
                end
`ifndef CICLO_UNICO_EN
                c_CORRIGE: begin
                    r_sr <= {w_corr, r_sr[N_BITS-1:0]};
                end
`endif
                c_DESLOCA: begin
`ifdef CICLO_UNICO_EN
                    // Corrected digits feed the shifter directly
                    r_sr <= {w_corr[c_BCD_W-2:0], r_sr[N_BITS-1:0], 1'b0};
`else
                    r_sr <= {r_sr[c_SR_W-2:0], 1'b0};
`endif
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
                c_FIM: begin
                    r_bcd  <= r_sr[c_SR_W-1 -: c_BCD_W];
                    r_done <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_controlador_double_dabble.sv
`default_nettype none
// ============================================================================
//  Module   : tb_controlador_double_dabble
//  Purpose  : Directed self-checking bench for controlador_double_dabble.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_controlador_double_dabble;

`ifdef CICLO_UNICO_EN
    localparam int c_LAT = 9;
`else
    localparam int c_LAT = 17;
`endif
    localparam int c_TIMEOUT = 60;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;

    int n_vec = 0;
    int n_err = 0;

    controlador_double_dabble #(
        .N_BITS    (8),
        .N_DIGITOS (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference: three BCD digits of v
    function automatic logic [11:0] ref_bcd(input int v);
        ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Present a start pulse; returns just after the accepting edge
    task automatic begin_conv(input logic [7:0] v);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // Count edges until done is seen; -1 when the bound expires
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < c_TIMEOUT) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (done !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; bin_in = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_vec++; if (bcd_out !== 12'h000) begin n_err++; $display("FAIL reset_bcd: got %h expected 000", bcd_out); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero;
        int cyc;
        begin_conv(8'd0);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL zero_busy: got %b expected 1", busy); end
        wait_done(cyc);
        n_vec++; if (cyc != c_LAT) begin n_err++; $display("FAIL zero_latency: got %0d expected %0d", cyc, c_LAT); end
        n_vec++; if (bcd_out !== 12'h000) begin n_err++; $display("FAIL zero_bcd: got %h expected 000", bcd_out); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy_end: got %b expected 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_values;
        logic [7:0]  vals [3] = '{8'd255, 8'd99, 8'd128};
        logic [11:0] exps [3] = '{12'h255, 12'h099, 12'h128};
        int cyc;
        for (int i = 0; i < 3; i++) begin
            begin_conv(vals[i]);
            wait_done(cyc);
            n_vec++; if (cyc != c_LAT) begin n_err++; $display("FAIL value_latency[%0d]: got %0d expected %0d", i, cyc, c_LAT); end
            n_vec++; if (bcd_out !== exps[i]) begin n_err++; $display("FAIL value_bcd[%0d]: got %h expected %h", i, bcd_out, exps[i]); end
            @(posedge clk); #1;
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL done_width[%0d]: got %b expected 0", i, done); end
            n_vec++; if (bcd_out !== exps[i]) begin n_err++; $display("FAIL value_hold[%0d]: got %h expected %h", i, bcd_out, exps[i]); end
        end
    endtask

    task automatic test_start_ignored;
        int cyc;
        int pulses;
        begin_conv(8'd37);
        repeat (4) @(posedge clk);
        #1;
        begin_conv(8'd200);
        wait_done(cyc);
        if (cyc >= 0) cyc += 5;
        n_vec++; if (cyc != c_LAT) begin n_err++; $display("FAIL ignore_latency: got %0d expected %0d", cyc, c_LAT); end
        n_vec++; if (bcd_out !== 12'h037) begin n_err++; $display("FAIL ignore_bcd: got %h expected 037", bcd_out); end
        pulses = 0;
        for (int k = 0; k < 2*c_LAT; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        n_vec++; if (pulses != 0) begin n_err++; $display("FAIL ignore_extra_done: got %0d expected 0", pulses); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        int pulses;
        begin_conv(8'd200);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        n_vec++; if (bcd_out !== 12'h000) begin n_err++; $display("FAIL midreset_bcd: got %h expected 000", bcd_out); end
        pulses = 0;
        for (int k = 0; k < c_LAT + 5; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        n_vec++; if (pulses != 0) begin n_err++; $display("FAIL midreset_done: got %0d expected 0", pulses); end
        begin_conv(8'd7);
        wait_done(cyc);
        n_vec++; if (cyc != c_LAT) begin n_err++; $display("FAIL after_reset_latency: got %0d expected %0d", cyc, c_LAT); end
        n_vec++; if (bcd_out !== 12'h007) begin n_err++; $display("FAIL after_reset_bcd: got %h expected 007", bcd_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int cyc;
        begin_conv(8'd45);
        wait_done(cyc);
        n_vec++; if (bcd_out !== 12'h045) begin n_err++; $display("FAIL b2b_first: got %h expected 045", bcd_out); end
        // Start raised during the done cycle must be accepted
        begin_conv(8'd180);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        n_vec++; if (bcd_out !== 12'h045) begin n_err++; $display("FAIL b2b_hold: got %h expected 045", bcd_out); end
        wait_done(cyc);
        n_vec++; if (cyc != c_LAT) begin n_err++; $display("FAIL b2b_latency: got %0d expected %0d", cyc, c_LAT); end
        n_vec++; if (bcd_out !== 12'h180) begin n_err++; $display("FAIL b2b_second: got %h expected 180", bcd_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep;
        int cyc;
        for (int v = 0; v < 256; v++) begin
            begin_conv(8'(v));
            wait_done(cyc);
            n_vec++;
            if (cyc != c_LAT || bcd_out !== ref_bcd(v)) begin
                n_err++;
                $display("FAIL sweep[%0d]: got %h after %0d cycles expected %h after %0d", v, bcd_out, cyc, ref_bcd(v), c_LAT);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_zero;
        test_values;
        test_start_ignored;
        test_reset_mid;
        test_back_to_back;
        test_sweep;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
